// File: rtl/rr_burst_scheduler.sv
// Four-requester round-robin burst scheduler for a shared single-beat bus.
// An owner keeps the bus until it signals last, exhausts its beat quantum,
// drops its request on an idle cycle, or sits idle too long. Every release
// is followed by exactly one dead (turnaround) cycle before the next grant.
module rr_burst_scheduler #(
  parameter int unsigned MAX_BURST    = 8,
  parameter int unsigned IDLE_TIMEOUT = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] req_i,
  input  logic       beat_i,
  input  logic [3:0] last_i,
  output logic [3:0] gnt_o,
  output logic [1:0] gnt_id_o,
  output logic       busy_o,
  output logic       rel_pulse_o,
  output logic [1:0] rel_cause_o
);

  localparam int unsigned BcW = $clog2(MAX_BURST + 1);
  // A disabled timeout still needs a legal (1-bit) counter width.
  localparam int unsigned IcW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

  localparam logic [BcW-1:0] BeatLast = BcW'(MAX_BURST - 1);
  localparam logic [IcW-1:0] IdleLast = IcW'(IDLE_TIMEOUT - 1);

  localparam logic [1:0] CauseLast    = 2'd0;
  localparam logic [1:0] CauseQuantum = 2'd1;
  localparam logic [1:0] CauseDrop    = 2'd2;
  localparam logic [1:0] CauseTimeout = 2'd3;

  typedef enum logic [1:0] {StIdle, StGrant, StTurn} state_e;

  state_e           state_q;
  logic [1:0]       ptr_q;
  logic [BcW-1:0]   beat_cnt_q;
  logic [IcW-1:0]   idle_cnt_q;
  logic [3:0]       gnt_q;
  logic [1:0]       gnt_id_q;
  logic             busy_q;
  logic             rel_pulse_q;
  logic [1:0]       rel_cause_q;

  logic             win_found;
  logic [1:0]       win_id;
  logic [1:0]       scan_idx;
  logic             rel;
  logic [1:0]       rel_cause;

  // Round-robin scan starting just after the last released owner.
  always_comb begin
    win_found = 1'b0;
    win_id    = 2'd0;
    scan_idx  = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      scan_idx = ptr_q + 2'(k);
      if (!win_found && req_i[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  // Release decision for the current owner; earlier checks take precedence.
  always_comb begin
    rel       = 1'b0;
    rel_cause = CauseLast;
    if (beat_i && last_i[gnt_id_q]) begin
      rel       = 1'b1;
      rel_cause = CauseLast;
    end else if (beat_i && (beat_cnt_q == BeatLast)) begin
      rel       = 1'b1;
      rel_cause = CauseQuantum;
    end else if (!beat_i && !req_i[gnt_id_q]) begin
      rel       = 1'b1;
      rel_cause = CauseDrop;
    end else if ((IDLE_TIMEOUT != 0) && !beat_i && (idle_cnt_q == IdleLast)) begin
      rel       = 1'b1;
      rel_cause = CauseTimeout;
    end
  end

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      ptr_q       <= 2'd3;
      beat_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      gnt_q       <= 4'b0000;
      gnt_id_q    <= 2'd0;
      busy_q      <= 1'b0;
      rel_pulse_q <= 1'b0;
      rel_cause_q <= 2'd0;
    end else begin
      rel_pulse_q <= 1'b0;
      unique case (state_q)
        StIdle, StTurn: begin
          if (win_found) begin
            state_q    <= StGrant;
            gnt_q      <= 4'b0001 << win_id;
            gnt_id_q   <= win_id;
            busy_q     <= 1'b1;
            beat_cnt_q <= '0;
            idle_cnt_q <= '0;
          end else begin
            state_q <= StIdle;
          end
        end
        StGrant: begin
          if (rel) begin
            state_q     <= StTurn;
            gnt_q       <= 4'b0000;
            busy_q      <= 1'b0;
            rel_pulse_q <= 1'b1;
            rel_cause_q <= rel_cause;
            ptr_q       <= gnt_id_q;
          end else if (beat_i) begin
            beat_cnt_q <= beat_cnt_q + BcW'(1);
            idle_cnt_q <= '0;
          end else if (idle_cnt_q != '1) begin
            idle_cnt_q <= idle_cnt_q + IcW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          gnt_q   <= 4'b0000;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_id_o    = gnt_id_q;
  assign busy_o      = busy_q;
  assign rel_pulse_o = rel_pulse_q;
  assign rel_cause_o = rel_cause_q;

endmodule

// File: tb/tb_rr_burst_scheduler.sv
// Randomized bench for rr_burst_scheduler: two instances (default params and
// MAX_BURST=1 with no timeout) share stimulus and are checked every cycle
// against a behavioural owner/priority model.
module tb_rr_burst_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       beat = 1'b0;
  logic [3:0] last = 4'b0000;

  logic [3:0] a_gnt, b_gnt;
  logic [1:0] a_gid, b_gid, a_cause, b_cause;
  logic       a_busy, b_busy, a_pulse, b_pulse;

  always #5 clk = ~clk;

  rr_burst_scheduler #(.MAX_BURST(8), .IDLE_TIMEOUT(4)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req), .beat_i(beat), .last_i(last),
    .gnt_o(a_gnt), .gnt_id_o(a_gid), .busy_o(a_busy),
    .rel_pulse_o(a_pulse), .rel_cause_o(a_cause)
  );

  rr_burst_scheduler #(.MAX_BURST(1), .IDLE_TIMEOUT(0)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req), .beat_i(beat), .last_i(last),
    .gnt_o(b_gnt), .gnt_id_o(b_gid), .busy_o(b_busy),
    .rel_pulse_o(b_pulse), .rel_cause_o(b_cause)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: an owner of -1 means "nobody holds the bus"; arbitration happens on
  // any edge without an owner, which naturally yields the one-cycle gap.
  int mb [2] = '{8, 1};
  int it [2] = '{4, 0};
  int m_own [2];
  int m_prev [2];
  int m_bc [2];
  int m_ic [2];
  int m_gid [2];
  int m_pulse [2];
  int m_cause [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_own[i]   = -1;
      m_prev[i]  = 3;
      m_bc[i]    = 0;
      m_ic[i]    = 0;
      m_gid[i]   = 0;
      m_pulse[i] = 0;
      m_cause[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input logic [3:0] r, input logic b, input logic [3:0] l);
    int cause;
    int found;
    int c;
    m_pulse[i] = 0;
    if (m_own[i] < 0) begin
      found = 0;
      for (int k = 1; k <= 4; k++) begin
        c = (m_prev[i] + k) % 4;
        if (found == 0 && r[c]) begin
          found    = 1;
          m_own[i] = c;
          m_gid[i] = c;
          m_bc[i]  = 0;
          m_ic[i]  = 0;
        end
      end
    end else begin
      cause = -1;
      if (b && l[m_own[i]])                                cause = 0;
      else if (b && m_bc[i] == mb[i] - 1)                  cause = 1;
      else if (!b && !r[m_own[i]])                         cause = 2;
      else if (it[i] != 0 && !b && m_ic[i] == it[i] - 1)   cause = 3;
      if (cause >= 0) begin
        m_pulse[i] = 1;
        m_cause[i] = cause;
        m_prev[i]  = m_own[i];
        m_own[i]   = -1;
      end else if (b) begin
        m_bc[i]++;
        m_ic[i] = 0;
      end else begin
        m_ic[i]++;
      end
    end
  endtask

  task automatic check_inst(input int i, input logic [3:0] g, input logic [1:0] gid,
                            input logic bz, input logic rp, input logic [1:0] rc);
    logic [3:0] eg;
    eg = (m_own[i] < 0) ? 4'b0000 : (4'b0001 << m_own[i]);
    check_eq($sformatf("u%0d gnt", i), 32'(g), 32'(eg));
    check_eq($sformatf("u%0d gnt_id", i), 32'(gid), 32'(m_gid[i]));
    check_eq($sformatf("u%0d busy", i), 32'(bz), 32'(m_own[i] >= 0));
    check_eq($sformatf("u%0d rel_pulse", i), 32'(rp), 32'(m_pulse[i]));
    if (m_pulse[i] != 0) check_eq($sformatf("u%0d rel_cause", i), 32'(rc), 32'(m_cause[i]));
  endtask

  task automatic check_both();
    check_inst(0, a_gnt, a_gid, a_busy, a_pulse, a_cause);
    check_inst(1, b_gnt, b_gid, b_busy, b_pulse, b_cause);
  endtask

  initial begin
    int mode;
    int last_rst;
    int n_rst;
    logic [3:0] held;

    model_reset();
    mode     = 0;
    last_rst = 0;
    n_rst    = 0;
    held     = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check_both();
    rst = 1'b0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 64 == 0) begin
        mode = $urandom_range(0, 3);
        held = 4'($urandom_range(1, 15));
      end
      case (mode)
        // Everyone requesting, back-to-back beats, never last: quantum rotation.
        1: begin
          req = 4'b1111; beat = 1'b1; last = 4'b0000;
        end
        // Steady requests with no beats: timeouts (or drops when owner idle).
        2: begin
          req = held; beat = 1'b0; last = 4'($urandom);
        end
        // Mostly beating with occasional last and request toggles.
        3: begin
          for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
          beat = ($urandom_range(0, 7) != 0);
          for (int b = 0; b < 4; b++) last[b] = ($urandom_range(0, 9) == 0);
        end
        default: begin
          for (int b = 0; b < 4; b++) if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
          beat = $urandom_range(0, 1) == 1;
          last = 4'($urandom);
        end
      endcase

      @(posedge clk);
      model_step(0, req, beat, last);
      model_step(1, req, beat, last);
      #1;
      check_both();

      // Asynchronous reset in the middle of a burst; outputs must clear at once.
      if (m_own[0] >= 0 && m_bc[0] == 5 && cyc - last_rst > 300) begin
        last_rst = cyc;
        n_rst++;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_both();
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 4'b1010;
        beat = 1'b0;
        last = 4'b0000;
        @(posedge clk);
        model_step(0, req, beat, last);
        model_step(1, req, beat, last);
        #1;
        check_both();
        check_eq("post-reset winner", 32'(a_gid), 32'd1);
      end
    end

    check_eq("mid-burst resets exercised", 32'(n_rst > 0), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_burst_scheduler.md
Name: rr_burst_scheduler

Overview:
- Four-requester round-robin scheduler for a shared single-beat bus.
- Each winner holds the bus for a burst, bounded by a beat quantum and an idle timeout.
- A one-cycle turnaround gap is inserted between owners.
- Sits between the requesting masters and the shared bus mux; gnt drives the mux select and gates each master's beat/last.

Parameters:
- MAX_BURST, 8, max beats per grant (quantum); legal range >= 1.
- IDLE_TIMEOUT, 4, consecutive no-beat cycles in GRANT before forced release; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- req  in  4  per-requester bus request, level; bit i = requester i.
- beat  in  1  a data beat transferred this cycle by the current owner.
- last  in  4  per-requester final-beat flag; only sampled with beat, and only bit gnt_id.
- gnt  out  4  one-hot grant, registered; all-zero when no owner.
- gnt_id  out  2  encoded owner index, registered; holds its last value when gnt=0.
- busy  out  1  registered; 1 while in GRANT.
- rel_pulse  out  1  one-cycle registered pulse on the cycle gnt drops.
- rel_cause  out  2  valid with rel_pulse: 0 = last, 1 = quantum, 2 = drop, 3 = timeout.

Behaviour:
- Reset (async, immediate, including mid-burst):
  - gnt=0, gnt_id=0, busy=0, rel_pulse=0, rel_cause=0.
  - state=IDLE, beat_cnt=0, idle_cnt=0.
  - ptr=3, so req0 has top priority after reset.
- States: IDLE, GRANT, TURN. All outputs are registered; no combinational path from inputs to outputs.
- Arbitration:
  - Runs in IDLE and TURN.
  - Winner = first i with req[i]=1, scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - If any req at the edge: next state GRANT, gnt=onehot(winner), gnt_id=winner, busy=1, beat_cnt=0, idle_cnt=0.
  - Otherwise the state goes to / stays in IDLE.
- IDLE to grant latency: req rising in IDLE gives gnt high on the following edge (1 cycle).
- GRANT:
  - beat=1: beat_cnt+1, idle_cnt=0.
  - beat=0: idle_cnt+1.
  - Release conditions, evaluated each edge in GRANT, first match wins:
    1. beat & last[gnt_id] -> cause 0.
    2. beat & beat_cnt==MAX_BURST-1 -> cause 1.
    3. !beat & !req[gnt_id] -> cause 2.
    4. IDLE_TIMEOUT!=0 & !beat & idle_cnt==IDLE_TIMEOUT-1 -> cause 3.
  - The counter checks in 2 and 4 use pre-increment values.
  - On release: next state TURN, gnt=0, busy=0, rel_pulse=1, rel_cause=cause, ptr=gnt_id. gnt_id keeps its value.
- TURN:
  - Exactly one cycle with gnt=0; rel_pulse clears next edge.
  - Arbitration happens at the end of TURN, so the gap between owners is exactly 1 cycle.
  - A requester that releases while still requesting is lowest priority in that arbitration. It re-wins only if no other req is high.
- Boundary conditions:
  - beat, last and req are ignored outside GRANT.
  - last without beat is ignored.
  - last bits of non-owners are ignored.
  - beat while req[gnt_id]=0 is counted normally; drop applies only on no-beat cycles.
  - MAX_BURST=1 releases on every beat, cause 0 if last is also set, else 1.
  - beat_cnt is sized clog2(MAX_BURST+1) and never exceeds MAX_BURST-1 in GRANT.
  - idle_cnt saturates at its width; it is never used when IDLE_TIMEOUT=0.
  - Simultaneous last and quantum expiry reports cause 0.
  - Simultaneous drop and timeout reports cause 2.

Test Plan:
1. Reset, then req=0001 -> gnt=0001 one cycle later, gnt_id=0, busy=1. Three beats with last[0] on the third -> gnt=0000, rel_pulse=1, rel_cause=0. req0 still high -> gnt=0001 again after one TURN cycle.
2. req=1111 held; each owner sends beat every cycle, never last, MAX_BURST=8 -> grant order 0,1,2,3,0. Each grant lasts 8 beats; every release is rel_cause=1 followed by a 1-cycle gap.
3. Owner 2 granted, no beats, req2 held, IDLE_TIMEOUT=4 -> gnt drops after 4 GRANT cycles, rel_cause=3. With req1 also high, next grant = 1 only if req3/req0 are low (scan 3,0,1).
4. Owner 1 granted; req1 deasserted on cycle 2 with beat=0 -> release that edge, rel_cause=2. Pending req3 -> gnt=1000 after TURN.
5. MAX_BURST=8: on the 8th beat, last[gnt_id]=1 -> rel_cause=0 (priority check). Non-owner last bits toggling during GRANT -> no effect.
6. rst asserted mid-burst (beat_cnt=5) -> gnt=0 and busy=0 immediately, without waiting for a clock. After deassert with req=1010 -> req1 wins first (ptr=3).
